// File: rtl/ras_verifier.sv
// Execute-side checker for return-address-stack predictions: queues popped
// predictions in order, compares them with resolved targets and keeps hit/miss statistics.
module ras_verifier #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 31
) (
    input  logic                     s_clk_i,
    input  logic                     s_resetn_i,
    input  logic                     s_flush_i,
    input  logic                     s_pred_valid_i,
    input  logic [AW-1:0]            s_pred_addr_i,
    output logic                     s_pred_ready_o,
    input  logic                     s_res_valid_i,
    input  logic                     s_res_pred_i,
    input  logic [AW-1:0]            s_res_addr_i,
    output logic                     s_mispredict_o,
    output logic [AW-1:0]            s_correct_addr_o,
    output logic                     s_ras_inv_o,
    output logic                     s_err_o,
    output logic [$clog2(DEPTH):0]   s_count_o,
    output logic [15:0]              s_hit_cnt_o,
    output logic [15:0]              s_miss_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_RECOVER = 1'b1;

    logic          r_state;
    logic          w_state_nxt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_mem [DEPTH];
    logic          r_cmp_v;
    logic          r_cmp_miss;
    logic [AW-1:0] r_correct_addr;
    logic          r_err;
    logic [15:0]   r_hit_cnt;
    logic [15:0]   r_miss_cnt;

    logic          w_run;
    logic          w_enq;
    logic          w_deq;
    logic          w_err;
    logic          w_miss;
    logic [AW-1:0] w_head;

    assign w_head         = r_mem[r_rptr];
    assign s_pred_ready_o = (r_count != CW'(DEPTH)) && (r_state == ST_RUN);

    // Resolve decode and next state; flush overrides everything, a miss enters RECOVER.
    always_comb begin
        w_run       = 1'b0;
        w_enq       = 1'b0;
        w_deq       = 1'b0;
        w_err       = 1'b0;
        w_miss      = 1'b0;
        w_state_nxt = r_state;

        w_run  = (r_state == ST_RUN) && !s_flush_i;
        w_enq  = s_pred_valid_i && s_pred_ready_o && !s_flush_i;
        w_deq  = w_run && s_res_valid_i && s_res_pred_i && (r_count != '0);
        w_err  = w_run && s_res_valid_i && s_res_pred_i && (r_count == '0);
        w_miss = w_deq && (w_head != s_res_addr_i);

        case (r_state)
            ST_RUN:  if (w_miss) w_state_nxt = ST_RECOVER;
            default: w_state_nxt = ST_RUN;
        endcase
        if (s_flush_i) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) r_state <= ST_RUN;
        else             r_state <= w_state_nxt;
    end

    // Pointers and count; younger predictions are wrong-path after a miss.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i || s_flush_i || w_miss) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + PW'(1);
            if (w_deq) r_rptr <= r_rptr + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (w_enq) r_mem[r_wptr] <= s_pred_addr_i;
    end

    // Compare slot: the result of a dequeue is presented the following cycle.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            r_cmp_v        <= 1'b0;
            r_cmp_miss     <= 1'b0;
            r_correct_addr <= '0;
            r_err          <= 1'b0;
        end else begin
            r_cmp_v    <= w_deq;
            r_cmp_miss <= w_miss;
            r_err      <= w_err;
            if (w_deq) r_correct_addr <= s_res_addr_i;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_deq && !w_miss && (r_hit_cnt != 16'hFFFF)) r_hit_cnt  <= r_hit_cnt + 16'd1;
            if (w_miss && (r_miss_cnt != 16'hFFFF))          r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign s_mispredict_o   = r_cmp_v && r_cmp_miss;
    assign s_ras_inv_o      = r_cmp_v && r_cmp_miss;
    assign s_correct_addr_o = r_correct_addr;
    assign s_err_o          = r_err;
    assign s_count_o        = r_count;
    assign s_hit_cnt_o      = r_hit_cnt;
    assign s_miss_cnt_o     = r_miss_cnt;

endmodule

// File: tb/tb_ras_verifier.sv
// Scoreboard bench for ras_verifier: a queue-based reference model predicts each
// resolve response, and a monitor pops and checks them as the DUT presents them.
module tb_ras_verifier;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 31;

    localparam int K_HIT  = 0;
    localparam int K_MISS = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [30:0] addr;
        int          hit;
        int          miss;
    } resp_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          pred_valid;
    logic [AW-1:0] pred_addr;
    logic          pred_ready;
    logic          res_valid;
    logic          res_pred;
    logic [AW-1:0] res_addr;
    logic          mispredict;
    logic [AW-1:0] correct_addr;
    logic          ras_inv;
    logic          err;
    logic [2:0]    count;
    logic [15:0]   hit_cnt;
    logic [15:0]   miss_cnt;

    ras_verifier #(.DEPTH(DEPTH), .AW(AW)) dut (
        .s_clk_i          (clk),
        .s_resetn_i       (rst_n),
        .s_flush_i        (flush),
        .s_pred_valid_i   (pred_valid),
        .s_pred_addr_i    (pred_addr),
        .s_pred_ready_o   (pred_ready),
        .s_res_valid_i    (res_valid),
        .s_res_pred_i     (res_pred),
        .s_res_addr_i     (res_addr),
        .s_mispredict_o   (mispredict),
        .s_correct_addr_o (correct_addr),
        .s_ras_inv_o      (ras_inv),
        .s_err_o          (err),
        .s_count_o        (count),
        .s_hit_cnt_o      (hit_cnt),
        .s_miss_cnt_o     (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [30:0] m_q[$];
    bit          m_recover;
    int          m_hit;
    int          m_miss;
    resp_t       exp_q[$];

    int n_cmp;
    int n_err;
    bit skip_mon;
    logic [15:0] prev_hit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (m_q.size() != DEPTH) && !m_recover;
    endfunction

    task automatic push_resp(input int kind, input logic [30:0] addr);
        resp_t r;
        r.kind = kind;
        r.addr = addr;
        r.hit  = m_hit;
        r.miss = m_miss;
        exp_q.push_back(r);
    endtask

    // One clock of stimulus; the model advances as if the coming edge has happened.
    task automatic cycle(input logic pv, input logic [30:0] pa, input logic rv,
                         input logic rp, input logic [30:0] ra, input logic fl);
        logic [30:0] head;
        bit          enq;
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_q.size()));
        chk("pred_ready", 32'(pred_ready), 32'(model_ready()));
        pred_valid = pv;
        pred_addr  = pa;
        res_valid  = rv;
        res_pred   = rp;
        res_addr   = ra;
        flush      = fl;
        enq = pv && model_ready();
        if (fl) begin
            m_q.delete();
            m_recover = 0;
        end else if (m_recover) begin
            m_recover = 0;
        end else if (rv && rp && m_q.size() == 0) begin
            push_resp(K_ERR, '0);
            if (enq) m_q.push_back(pa);
        end else if (rv && rp) begin
            head = m_q.pop_front();
            if (head == ra) begin
                if (m_hit != 65535) m_hit++;
                push_resp(K_HIT, '0);
                if (enq) m_q.push_back(pa);
            end else begin
                if (m_miss != 65535) m_miss++;
                push_resp(K_MISS, ra);
                m_q.delete();
                m_recover = 1;
            end
        end else if (enq) begin
            m_q.push_back(pa);
        end
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, '0, 0);
    endtask

    task automatic enq(input logic [30:0] a);
        cycle(1, a, 0, 0, '0, 0);
    endtask

    task automatic res(input logic [30:0] a);
        cycle(0, '0, 1, 1, a, 0);
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #1;
        skip_mon   = 1;
        rst_n      = 0;
        pred_valid = 0;
        res_valid  = 0;
        res_pred   = 0;
        flush      = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        m_q.delete();
        m_recover = 0;
        m_hit     = 0;
        m_miss    = 0;
        exp_q.delete();
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(pred_ready), 1);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_ras_inv", 32'(ras_inv), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_correct_addr", 32'(correct_addr), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_miss_cnt", 32'(miss_cnt), 0);
        @(negedge clk);
        #1;
        skip_mon = 0;
    endtask

    // Monitor: every response the DUT presents must match the oldest expected one.
    initial begin
        resp_t e;
        int    kind;
        bit    ev_hit;
        forever begin
            @(negedge clk);
            if (skip_mon) begin
                prev_hit = hit_cnt;
            end else begin
                ev_hit   = (hit_cnt != prev_hit);
                prev_hit = hit_cnt;
                if (mispredict || err || ev_hit) begin
                    kind = mispredict ? K_MISS : (err ? K_ERR : K_HIT);
                    chk("event_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("resp_kind", 32'(kind), 32'(e.kind));
                        chk("hit_cnt", 32'(hit_cnt), 32'(e.hit));
                        chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
                        chk("ras_inv", 32'(ras_inv), 32'(e.kind == K_MISS));
                        if (e.kind == K_MISS) chk("correct_addr", 32'(correct_addr), 32'(e.addr));
                    end
                end else begin
                    chk("ras_inv_quiet", 32'(ras_inv), 0);
                end
            end
        end
    end

    initial begin
        logic [30:0] a;
        logic [30:0] r;
        n_cmp      = 0;
        n_err      = 0;
        skip_mon   = 1;
        prev_hit   = '0;
        rst_n      = 0;
        flush      = 0;
        pred_valid = 0;
        pred_addr  = '0;
        res_valid  = 0;
        res_pred   = 0;
        res_addr   = '0;
        m_recover  = 0;
        m_hit      = 0;
        m_miss     = 0;

        do_reset();

        // Simple hit
        enq(31'h1000);
        res(31'h1000);
        idle();

        // Mispredict discards the younger entry and blocks one cycle
        enq(31'h100);
        enq(31'h200);
        res(31'h104);
        idle();
        idle();

        // Fill, refuse while full, drain with wrapped pointers
        enq(31'h10);
        enq(31'h20);
        enq(31'h30);
        enq(31'h40);
        cycle(1, 31'h99, 1, 1, 31'h10, 0);
        res(31'h20);
        res(31'h30);
        res(31'h40);
        enq(31'h50);
        res(31'h50);
        idle();

        // Resolve with nothing recorded
        res(31'h777);
        idle();

        // Non-predicted resolve is ignored
        enq(31'h60);
        cycle(0, '0, 1, 0, 31'h61, 0);
        res(31'h60);
        idle();

        // Mispredict followed by a flush
        enq(31'h80);
        res(31'h81);
        cycle(0, '0, 0, 0, '0, 1);
        idle();
        idle();

        // Miss counter saturation
        @(posedge clk);
        #1;
        force dut.r_miss_cnt = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.r_miss_cnt;
        m_miss = 16'hFFFD;
        for (int i = 0; i < 3; i++) begin
            enq(31'h300 + 31'(i));
            res(31'h3FF);
            idle();
        end
        idle();

        do_reset();

        // Randomized traffic with a small address pool so hits are frequent
        for (int i = 0; i < 2000; i++) begin
            a = 31'($urandom_range(0, 7)) << 2;
            if (m_q.size() != 0 && $urandom_range(0, 2) != 0) r = m_q[0];
            else r = 31'($urandom_range(0, 7)) << 2;
            cycle(1'($urandom_range(0, 1)), a,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0), r,
                  1'($urandom_range(0, 24) == 0));
        end
        idle();
        idle();
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_verifier.md
# ras_verifier

Execute-side checker for return-address predictions issued by the fetch-stage return address stack. Records each popped prediction in a small in-order queue. When the execute stage resolves a predicted return, compares the real target with the oldest recorded prediction, reports a mispredict with the correct address, and invalidates the fetch-side stack. Keeps saturating hit/miss statistics for performance counters.

## Interface
- DEPTH, 4, prediction queue entries; power of two, ≥2
- AW, 31, address width: {word address[29:0], halfword bit}
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset; synchronous, active-low
- s_flush_i  in  1  pipeline flush; drops all recorded predictions and the compare stage
- s_pred_valid_i  in  1  fetch popped a prediction this cycle
- s_pred_addr_i  in  AW  predicted target
- s_pred_ready_o  out  1  queue can accept a prediction
- s_res_valid_i  in  1  execute resolves a control-transfer instruction
- s_res_pred_i  in  1  resolved instruction was fetched on a predicted return
- s_res_addr_i  in  AW  actual target
- s_mispredict_o  out  1  one-cycle pulse: prediction was wrong
- s_correct_addr_o  out  AW  actual target, valid with s_mispredict_o
- s_ras_inv_o  out  1  one-cycle pulse to the stack's invalidate input
- s_err_o  out  1  one-cycle pulse: resolution with no recorded prediction
- s_count_o  out  $clog2(DEPTH)+1  queued predictions
- s_hit_cnt_o  out  16  saturating correct-prediction count
- s_miss_cnt_o  out  16  saturating mispredict count

## Operation
- Queue: FIFO with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count.
- Enqueue when s_pred_valid_i & s_pred_ready_o. s_pred_ready_o = (count != DEPTH) & (state == RUN). It is registered-state-only; there is no combinational path from the resolve inputs.
- Dequeue when s_res_valid_i & s_res_pred_i & count != 0. The head entry and s_res_addr_i are latched into the compare stage.
- Same-cycle enqueue and dequeue: both occur and count is unchanged. If the queue was empty, the enqueued entry is not the one dequeued; the dequeue rule applies instead (see s_err_o).
- Resolve with s_res_pred_i & count == 0: no dequeue, no compare. s_err_o pulses next cycle, and no counter changes.
- Resolve with s_res_pred_i = 0: ignored entirely.
- Compare stage (one register slot, valid bit cmp_v) checks all AW bits for equality.
  - Equal: s_hit_cnt_o increments.
  - Different: s_mispredict_o = 1, s_correct_addr_o = latched actual, s_ras_inv_o = 1, s_miss_cnt_o increments.
- Counters saturate at 16'hFFFF and never wrap.
- FSM, two states:
  - RUN: normal operation.
  - RECOVER: entered on the cycle s_mispredict_o is high; lasts exactly one cycle, then returns to RUN.
- On the mispredict cycle all queue entries are discarded (pointers and count go to 0), because younger predictions belong to the wrong path.
- In RECOVER, s_pred_ready_o = 0, and resolve inputs are ignored.
- s_flush_i in any state:
  - pointers, count and cmp_v clear next cycle; state becomes RUN.
  - a compare stage holding data produces no output.
  - statistics counters are kept.
  - if flush and mispredict coincide, the mispredict outputs still pulse that cycle, since they come from registered state.

## Timing
- Reset values (s_resetn_i low at a clock edge): state RUN, count 0, pointers 0, cmp_v 0, s_mispredict_o 0, s_ras_inv_o 0, s_err_o 0, s_correct_addr_o 0, s_hit_cnt_o 0, s_miss_cnt_o 0, s_pred_ready_o 1 from the first cycle after reset.
- Reset mid-operation behaves the same as the reset values above, including the statistics counters.
- Enqueue in cycle N: s_count_o reflects it in N+1. The entry can be dequeued from N+1 onward.
- Resolve in cycle N: s_mispredict_o, s_ras_inv_o and s_correct_addr_o, or the hit-counter update, become visible in N+1.
- s_err_o also appears in N+1.
- Back-to-back resolves are supported every cycle in RUN.
- After a mispredict in N+1, the state is RECOVER in N+1. Predictions are accepted again from N+2.
- All outputs are driven from registers except s_pred_ready_o, which is decoded from registered state.

## Test plan
- Enqueue 0x0000_1000, then resolve with actual 0x0000_1000 → N+1: s_mispredict_o = 0, s_hit_cnt_o = 1, s_count_o = 0.
- Enqueue 0x100 and 0x200, then resolve with actual 0x104 → N+1: s_mispredict_o = 1, s_ras_inv_o = 1, s_correct_addr_o = 0x104, s_count_o = 0, s_pred_ready_o = 0. N+2: s_pred_ready_o = 1.
- Fill DEPTH = 4 entries (0x10, 0x20, 0x30, 0x40) → s_pred_ready_o = 0. Resolve with an enqueue in the same cycle → the enqueue is refused. Drain all four with matching addresses → 4 hits and the pointers have wrapped. Enqueue 0x50 → it lands at index 0.
- Resolve with s_res_pred_i = 1 while empty → N+1: s_err_o = 1, and both counters are unchanged.
- Enqueue 0x80, resolve with a mismatching address, and assert s_flush_i in the following cycle → the mispredict pulse appears once, the queue is empty, and the state returns to RUN.
- Preload s_miss_cnt_o to 16'hFFFF by forcing mismatches → a further mismatch leaves it at 16'hFFFF. Then assert s_resetn_i low for one cycle → all outputs return to their reset values.
